// File: rtl/core_pkg.sv
// Shared types and encodings for the addi-only core fetch/execute sequencer.
package core_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      TRAP_NONE    = 2'b00,
      TRAP_EBREAK  = 2'b01,
      TRAP_ILLEGAL = 2'b10,
      TRAP_TIMEOUT = 2'b11
   } trap_e;

   localparam logic [6:0]  OPC_OP_IMM       = 7'b0010011;
   localparam logic [2:0]  F3_ADDI          = 3'b000;
   localparam logic [31:0] INST_EBREAK      = 32'h00100073;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h80000000;

endpackage

// File: rtl/inst_classify.sv
// Combinational instruction classifier; new opcodes get added here as the core grows.
module inst_classify
   import core_pkg::*;
(
   input  logic [31:0] inst,
   output logic        is_addi,
   output logic        is_ebreak,
   output logic        is_illegal
);

   assign is_addi    = (inst[6:0] == OPC_OP_IMM) && (inst[14:12] == F3_ADDI);
   assign is_ebreak  = (inst == INST_EBREAK);
   assign is_illegal = !(is_addi || is_ebreak);

endmodule

// File: rtl/core_fetch_seq.sv
// Multi-cycle fetch/execute sequencer: fetch over valid/ready, latch instruction,
// retire addi with a one-cycle rf_wen pulse, stop with a sticky trap code.
//
// state | meaning
// FETCH | request valid at pc, waiting for imem_req_ready
// WAIT  | request accepted, waiting up to TIMEOUT cycles for the response
// EXEC  | one cycle: decode latched inst, retire or trap
// HALT  | stopped, outputs frozen until rst
module core_fetch_seq
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned TIMEOUT  = 16,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [31:0]      imem_req_addr,
   input  logic             imem_resp_valid,
   input  logic [31:0]      imem_resp_data,
   output logic [31:0]      pc,
   output logic [31:0]      inst,
   output logic             rf_wen,
   output logic             halted,
   output logic [1:0]       trap_code,
   output logic [CNT_W-1:0] retire_cnt
);

   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   state_e             state_q, state_d;
   trap_e              trap_q, trap_d;
   logic [31:0]        pc_q, pc_d;
   logic [31:0]        inst_q, inst_d;
   logic [CNT_W-1:0]   retire_q, retire_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;

   logic is_addi, is_ebreak, is_illegal;

   inst_classify u_classify (
      .inst       (inst_q),
      .is_addi    (is_addi),
      .is_ebreak  (is_ebreak),
      .is_illegal (is_illegal)
   );

   always_comb begin
      state_d  = state_q;
      trap_d   = trap_q;
      pc_d     = pc_q;
      inst_d   = inst_q;
      retire_d = retire_q;
      wait_d   = wait_q;
      case (state_q)
         FETCH: begin
            if (imem_req_ready) begin
               state_d = WAIT;
               wait_d  = '0;
            end
         end
         WAIT: begin
            // a response on the final wait cycle still beats the timeout
            if (imem_resp_valid) begin
               inst_d  = imem_resp_data;
               state_d = EXEC;
            end else if (wait_q == WAIT_LAST) begin
               trap_d  = TRAP_TIMEOUT;
               state_d = HALT;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         EXEC: begin
            if (is_addi) begin
               pc_d     = pc_q + 32'd4;
               retire_d = retire_q + CNT_W'(1);
               state_d  = FETCH;
            end else if (is_ebreak) begin
               retire_d = retire_q + CNT_W'(1);
               trap_d   = TRAP_EBREAK;
               state_d  = HALT;
            end else if (is_illegal) begin
               trap_d  = TRAP_ILLEGAL;
               state_d = HALT;
            end
         end
         HALT: begin
         end
         default: begin
            state_d = HALT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FETCH;
         trap_q   <= TRAP_NONE;
         pc_q     <= RESET_PC;
         inst_q   <= '0;
         retire_q <= '0;
         wait_q   <= '0;
      end else begin
         state_q  <= state_d;
         trap_q   <= trap_d;
         pc_q     <= pc_d;
         inst_q   <= inst_d;
         retire_q <= retire_d;
         wait_q   <= wait_d;
      end
   end

   assign imem_req_valid = (state_q == FETCH);
   assign imem_req_addr  = pc_q;
   assign pc             = pc_q;
   assign inst           = inst_q;
   assign rf_wen         = (state_q == EXEC) && is_addi;
   assign halted         = (state_q == HALT);
   assign trap_code      = trap_q;
   assign retire_cnt     = retire_q;

endmodule

// File: tb/tb_core_fetch_seq.sv
// Bench for core_fetch_seq: table of small programs with a responding memory model,
// plus hand-written reset-in-WAIT and pc-wrap sequences.
module tb_core_fetch_seq;

   localparam logic [31:0] RPC    = 32'h80000000;
   localparam logic [31:0] ADDI5  = 32'h00500093;
   localparam logic [31:0] ADDIM1 = 32'hFFF08113;
   localparam logic [31:0] EBRK   = 32'h00100073;
   localparam logic [31:0] SLLI   = 32'h00109093;
   localparam logic [31:0] RTYPE  = 32'h00001033;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid, imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic [31:0] pc, inst;
   logic        rf_wen, halted;
   logic [1:0]  trap_code;
   logic [31:0] retire_cnt;

   logic        w_rst = 1'b1, w_ready = 1'b0, w_resp_valid = 1'b0;
   logic [31:0] w_resp_data = '0;
   logic        w_req_valid, w_rf_wen, w_halted;
   logic [31:0] w_req_addr, w_pc, w_inst;
   logic [1:0]  w_trap;
   logic [1:0]  w_retire;

   always #5 clk = ~clk;

   core_fetch_seq u_dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data), .pc(pc), .inst(inst), .rf_wen(rf_wen),
      .halted(halted), .trap_code(trap_code), .retire_cnt(retire_cnt)
   );

   core_fetch_seq #(.RESET_PC(32'hFFFFFFFC), .TIMEOUT(16), .CNT_W(2)) u_wrap (
      .clk(clk), .rst(w_rst),
      .imem_req_valid(w_req_valid), .imem_req_ready(w_ready),
      .imem_req_addr(w_req_addr), .imem_resp_valid(w_resp_valid),
      .imem_resp_data(w_resp_data), .pc(w_pc), .inst(w_inst), .rf_wen(w_rf_wen),
      .halted(w_halted), .trap_code(w_trap), .retire_cnt(w_retire)
   );

   typedef struct {
      logic [2:0][31:0] w;
      logic [2:0]       is_addi;
      int               rdy_dly;
      int               rsp_dly;
      logic [1:0]       trap;
      int               retire;
      int               wens;
      logic [31:0]      pc;
      int               cyc;
   } vec_t;

   typedef struct {
      logic [31:0] inst;
      logic        wen;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[8];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] w0, w1, w2, input logic [2:0] a,
                               input int rdy, rsp, input logic [1:0] trap,
                               input int ret, wens, input logic [31:0] epc, input int cyc);
      vec_t v;
      v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
      v.is_addi = a; v.rdy_dly = rdy; v.rsp_dly = rsp;
      v.trap = trap; v.retire = ret; v.wens = wens; v.pc = epc; v.cyc = cyc;
      return v;
   endfunction

   task automatic do_reset();
      rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int          rdy_cnt = 0, rsp_cnt = 0, nfetch = 0, wens = 0, cyc, idx;
      bit          phase = 0, exec_next = 0;
      logic [31:0] mpc = RPC;
      logic [31:0] pc_h, inst_h, ret_h;
      logic [1:0]  trap_h;
      exp_t        e;
      do_reset();
      chk("rst_pc", pc, RPC);
      chk("rst_inst", inst, 32'h0);
      chk("rst_halted", halted, 0);
      chk("rst_trap", trap_code, 2'b00);
      chk("rst_retire", retire_cnt, 0);
      chk("rst_valid", imem_req_valid, 1);
      for (cyc = 0; cyc < 400; cyc++) begin
         if (exec_next) begin
            exec_next = 0;
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
               e = sb.pop_front();
               chk("exec_inst", inst, e.inst);
               chk("exec_wen", rf_wen, e.wen);
            end
         end else chk("idle_wen", rf_wen, 0);
         if (rf_wen) wens++;
         if (halted) break;
         imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
         if (!phase) begin
            if (imem_req_valid) begin
               chk("req_addr", imem_req_addr, mpc);
               chk("fetch_pc", pc, mpc);
               imem_resp_valid = 1'b1; imem_resp_data = RTYPE;
               if (rdy_cnt < v.rdy_dly) rdy_cnt++;
               else begin
                  imem_req_ready = 1'b1; phase = 1; rsp_cnt = 0; rdy_cnt = 0;
               end
            end
         end else begin
            chk("wait_valid", imem_req_valid, 0);
            if (rsp_cnt == v.rsp_dly) begin
               idx = (nfetch > 2) ? 2 : nfetch;
               imem_resp_valid = 1'b1; imem_resp_data = v.w[idx];
               e.inst = v.w[idx]; e.wen = v.is_addi[idx];
               sb.push_back(e);
               if (v.is_addi[idx]) mpc = mpc + 32'd4;
               nfetch++; phase = 0; exec_next = 1;
            end else rsp_cnt++;
         end
         @(negedge clk);
      end
      chk("end_halted", halted, 1);
      chk("end_trap", trap_code, v.trap);
      chk("end_retire", retire_cnt, v.retire);
      chk("end_pc", pc, v.pc);
      chk("end_wens", wens, v.wens);
      chk("end_sb_empty", sb.size(), 0);
      chk("end_valid", imem_req_valid, 0);
      if (v.cyc >= 0) chk("end_cycles", cyc, v.cyc);
      sb.delete();
      pc_h = pc; inst_h = inst; ret_h = retire_cnt; trap_h = trap_code;
      for (int i = 0; i < 6; i++) begin
         imem_req_ready = 1'($urandom); imem_resp_valid = 1'($urandom); imem_resp_data = ADDI5;
         @(negedge clk);
         chk("halt_pc", pc, pc_h);
         chk("halt_inst", inst, inst_h);
         chk("halt_retire", retire_cnt, ret_h);
         chk("halt_trap", trap_code, trap_h);
         chk("halt_sticky", halted, 1);
         chk("halt_wen", rf_wen, 0);
         chk("halt_valid", imem_req_valid, 0);
      end
   endtask

   initial begin
      vecs[0] = mk(ADDI5,  EBRK,   EBRK, 3'b001, 0,  0, 2'b01, 2, 1, RPC + 4, 6);
      vecs[1] = mk(ADDI5,  EBRK,   EBRK, 3'b001, 4,  0, 2'b01, 2, 1, RPC + 4, 14);
      vecs[2] = mk(ADDI5,  EBRK,   EBRK, 3'b001, 0, 15, 2'b01, 2, 1, RPC + 4, 36);
      vecs[3] = mk(ADDI5,  EBRK,   EBRK, 3'b001, 0, 16, 2'b11, 0, 0, RPC,     17);
      vecs[4] = mk(RTYPE,  EBRK,   EBRK, 3'b000, 0,  0, 2'b10, 0, 0, RPC,     3);
      vecs[5] = mk(EBRK,   ADDI5,  EBRK, 3'b010, 2,  1, 2'b01, 1, 0, RPC,     -1);
      vecs[6] = mk(ADDIM1, SLLI,   EBRK, 3'b001, 1,  3, 2'b10, 1, 1, RPC + 4, -1);
      vecs[7] = mk(ADDI5,  ADDIM1, EBRK, 3'b011, 0,  0, 2'b01, 3, 2, RPC + 8, 9);
      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // reset while in WAIT; the response arriving right after must be dropped
      do_reset();
      imem_req_ready = 1'b1;
      @(negedge clk);
      chk("rw_in_wait", imem_req_valid, 0);
      rst = 1'b1; imem_req_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = ADDI5;
      chk("rw_pc", pc, RPC);
      chk("rw_inst", inst, 32'h0);
      chk("rw_valid", imem_req_valid, 1);
      @(negedge clk);
      imem_resp_valid = 1'b0;
      chk("rw_stale_inst", inst, 32'h0);
      chk("rw_stale_wen", rf_wen, 0);
      chk("rw_still_fetch", imem_req_valid, 1);
      chk("rw_addr", imem_req_addr, RPC);
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = ADDI5;
      @(negedge clk);
      imem_resp_valid = 1'b0;
      chk("rw_exec_wen", rf_wen, 1);
      chk("rw_exec_inst", inst, ADDI5);
      @(negedge clk);
      chk("rw_pc_next", pc, RPC + 4);
      chk("rw_retire", retire_cnt, 1);

      // pc wraps past 0xFFFFFFFC; 2-bit retire counter wraps after four addi
      w_rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      w_rst = 1'b0; w_ready = 1'b1; w_resp_valid = 1'b1; w_resp_data = ADDI5;
      chk("wrap_rst_pc", w_pc, 32'hFFFFFFFC);
      chk("wrap_rst_addr", w_req_addr, 32'hFFFFFFFC);
      repeat (2) @(negedge clk);
      chk("wrap_exec_wen", w_rf_wen, 1);
      @(negedge clk);
      chk("wrap_pc", w_pc, 32'h0);
      chk("wrap_addr", w_req_addr, 32'h0);
      chk("wrap_valid", w_req_valid, 1);
      repeat (8) @(negedge clk);
      chk("wrap_retire3", w_retire, 2'd3);
      @(negedge clk);
      chk("wrap_retire_wrap", w_retire, 2'd0);
      chk("wrap_pc_c", w_pc, 32'hC);
      chk("wrap_not_halted", w_halted, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/core_fetch_seq.md
Name: core_fetch_seq

Overview:
Multi-cycle sequencer for the addi-only core datapath (PC register, instruction memory, 1r1w register file, immediate generator, ALU).
- Issues instruction fetches over a valid/ready request port and waits for a response.
- Latches the returned instruction and drives it to decode. Pulses the register-file write enable for one cycle per retired addi.
- Stops the core with a sticky trap code on ebreak, an illegal instruction, or a fetch timeout.

Parameters:
RESET_PC, 32'h80000000, PC value loaded on reset.
TIMEOUT, 16, max WAIT cycles without a response before a timeout trap (>=1).
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts request this cycle.
imem_req_addr  out  32  fetch address (= pc).
imem_resp_valid  in  1  response data valid.
imem_resp_data  in  32  fetched instruction word.
pc  out  32  current program counter.
inst  out  32  latched instruction, feeds decode, imm and rf address fields.
rf_wen  out  1  register-file write enable, one-cycle pulse.
halted  out  1  core stopped, sticky until rst.
trap_code  out  2  00 none, 01 ebreak, 10 illegal, 11 fetch timeout.
retire_cnt  out  CNT_W  count of retired instructions (addi and ebreak).

Behaviour:
- Reset (rst=1 at an edge) sets:
  - state=FETCH, pc=RESET_PC, inst=32'h0
  - rf_wen=0, halted=0, trap_code=00
  - retire_cnt=0, wait counter=0
- rst overrides every state, including mid-WAIT and HALT. A response arriving after reset is ignored unless the FSM is in WAIT.
- FETCH:
  - imem_req_valid=1, imem_req_addr=pc; valid stays high and addr stays stable until accepted.
  - On valid&&ready, go to WAIT with wait counter=0.
  - imem_resp_valid is ignored in FETCH.
- WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid=1: inst<=imem_resp_data, go to EXEC.
  - Otherwise the counter increments. If the counter==TIMEOUT-1 and there is no response, go to HALT with trap_code=11.
  - A response is therefore accepted on WAIT cycles 0..TIMEOUT-1. A response on the last cycle wins over timeout.
- EXEC (exactly one cycle), decode on inst:
  - addi (inst[6:0]=7'b0010011, inst[14:12]=3'b000):
    - rf_wen=1 combinationally this cycle; the datapath writes on this edge.
    - pc<=pc+4, 32-bit wrap (32'hFFFFFFFC -> 32'h0).
    - retire_cnt+1; go to FETCH.
  - ebreak (inst==32'h00100073): retire_cnt+1, pc unchanged, trap_code<=01, go to HALT.
  - Any other encoding: trap_code<=10, pc unchanged, no retire, go to HALT.
- rf_wen is 0 in every state except EXEC-with-addi; no write is ever issued in FETCH, WAIT or HALT.
- HALT:
  - halted=1; all outputs frozen; imem_req_valid=0; inputs ignored.
  - Left only by rst.
- retire_cnt wraps modulo 2^CNT_W.
- Throughput: with ready and response each asserted in the first eligible cycle, one addi retires every 3 cycles (FETCH, WAIT, EXEC).
- A response cannot arrive in the same cycle as request acceptance; the memory returns it no earlier than the following cycle.

Decomposition:
- Shared package core_pkg:
  - state enum {FETCH, WAIT, EXEC, HALT} (2 bits)
  - trap codes TRAP_NONE/EBREAK/ILLEGAL/TIMEOUT
  - OPC_OP_IMM=7'b0010011, F3_ADDI=3'b000, INST_EBREAK=32'h00100073
  - RESET_PC default
- One sub-module, inst_classify: combinational, inst -> {is_addi, is_ebreak, is_illegal}. It is reused later when more opcodes are added.
- The FSM, pc, the counters and the inst latch stay in core_fetch_seq.

Test Plan:
1. rst held 2 cycles, then released; memory always ready, 1-cycle response, program {addi x1,x0,5 (32'h00500093); ebreak}:
   - req addrs 0x80000000 then 0x80000004
   - rf_wen pulses exactly once, in the EXEC cycle of the first word
   - halted=1, trap_code=01, retire_cnt=2, pc=0x80000004
2. imem_req_ready low for 4 cycles in FETCH -> valid stays 1 and addr stays 0x80000000 throughout; the request is accepted on cycle 5 and pc is unchanged until EXEC.
3. Response delay = TIMEOUT-1 cycles after accept -> instruction accepted, no trap. Delay = TIMEOUT -> HALT with trap_code=11, rf_wen never asserted, retire_cnt=0.
4. Fetched word 32'h00001033 (R-type) -> trap_code=10, pc unchanged, retire_cnt unchanged, halted=1. Toggling resp_valid/ready afterwards has no effect.
5. rst asserted during WAIT with a response arriving the next cycle -> state=FETCH, pc=0x80000000, inst=0, the stale response is ignored, and the fetch restarts from RESET_PC.
6. Force pc=0xFFFFFFFC (RESET_PC override) and execute an addi -> pc becomes 0x00000000 and the next request addr is 0x00000000.
